// File: rtl/latch_load_arbiter.sv
// Two-requester arbiter feeding a shared latch-loader port: each granted word goes out as
// a low write (addr 0x0) and a high/commit write (addr 0x4), then waits for the loader's busy cycle.
module latch_load_arbiter #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned FIXED_PRI = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             done,
  output logic             done_id,
  output logic             err,
  input  logic             err_clr,
  output logic             active,
  output logic             ld_write_req,
  output logic [2:0]       ld_address,
  output logic [31:0]      ld_data,
  input  logic             ld_busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_hold;
  logic               r_owner;
  logic               r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_done;
  logic               r_done_id;
  logic               r_active;
  logic               r_ld_write_req;
  logic [2:0]         r_ld_address;
  logic [31:0]        r_ld_data;

  logic               w_grant0;
  logic               w_grant1;
  logic               w_can_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_data;
  logic               w_timeout;
  logic               w_done_nxt;
  logic               w_ld_wr_nxt;
  logic [2:0]         w_ld_addr_nxt;
  logic [31:0]        w_ld_data_nxt;

  // r_last holds the requester served most recently; the other one wins a tie
  assign w_grant0    = req0_valid & (~req1_valid | (FIXED_PRI != 0) | r_last);
  assign w_grant1    = req1_valid & ~w_grant0;
  assign w_can_grant = (r_state == S_IDLE) & ~ld_busy & rst_n;
  assign req0_ready  = w_can_grant & w_grant0;
  assign req1_ready  = w_can_grant & w_grant1;
  assign w_accept    = req0_ready | req1_ready;
  assign w_sel_data  = w_grant0 ? req0_data : req1_data;

  // Next state plus next values of the registered loader outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout     = 1'b0;
    w_done_nxt    = 1'b0;
    w_ld_wr_nxt   = 1'b0;
    w_ld_addr_nxt = 3'd0;
    w_ld_data_nxt = 32'd0;
    case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = S_WR_LO;
      S_WR_LO:     w_state_nxt = S_WR_HI;
      S_WR_HI:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (ld_busy) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!ld_busy) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default:     w_state_nxt = S_IDLE;
    endcase
    // WR_LO is only entered from IDLE, so the low half comes straight from the granted word
    case (w_state_nxt)
      S_WR_LO: begin
        w_ld_wr_nxt   = 1'b1;
        w_ld_data_nxt = w_sel_data[31:0];
      end
      S_WR_HI: begin
        w_ld_wr_nxt   = 1'b1;
        w_ld_addr_nxt = 3'd4;
        w_ld_data_nxt = 32'(r_hold[WIDTH-1:32]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_hold         <= '0;
      r_owner        <= 1'b0;
      r_last         <= 1'b1;
      r_cnt          <= '0;
      r_err          <= 1'b0;
      r_done         <= 1'b0;
      r_done_id      <= 1'b0;
      r_active       <= 1'b0;
      r_ld_write_req <= 1'b0;
      r_ld_address   <= 3'd0;
      r_ld_data      <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_active       <= (w_state_nxt != S_IDLE);
      r_ld_write_req <= w_ld_wr_nxt;
      r_ld_address   <= w_ld_addr_nxt;
      r_ld_data      <= w_ld_data_nxt;
      r_done         <= w_done_nxt;
      if (w_done_nxt) r_done_id <= r_owner;
      if (w_accept) begin
        r_hold  <= w_sel_data;
        r_owner <= req1_ready;
        r_last  <= req1_ready;
      end
      if (r_state == S_WR_HI) begin
        r_cnt <= '0;
      end else if ((r_state == S_WAIT_BUSY) && !ld_busy) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // A timeout in the same cycle as a clear leaves the flag set
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign done         = r_done;
  assign done_id      = r_done_id;
  assign err          = r_err;
  assign active       = r_active;
  assign ld_write_req = r_ld_write_req;
  assign ld_address   = r_ld_address;
  assign ld_data      = r_ld_data;

endmodule

// File: tb/tb_latch_load_arbiter.sv
// Directed bench for latch_load_arbiter: instance 0 is WIDTH=64/TIMEOUT=15/round-robin,
// instance 1 is WIDTH=48/TIMEOUT=3/fixed priority. Each has a small loader busy model.
module tb_latch_load_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid [2];
  logic        req1_valid [2];
  logic [63:0] req0_data  [2];
  logic [63:0] req1_data  [2];
  logic        req0_ready [2];
  logic        req1_ready [2];
  logic        done       [2];
  logic        done_id    [2];
  logic        err        [2];
  logic        err_clr    [2];
  logic        active     [2];
  logic        ld_write_req [2];
  logic [2:0]  ld_address [2];
  logic [31:0] ld_data    [2];
  logic        ld_busy    [2];
  logic        busy_force [2];
  logic        model_en   [2];
  int          busy_len   [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 64 : 48;
    int bcnt;

    latch_load_arbiter #(
      .WIDTH     (W),
      .TIMEOUT   ((g == 0) ? 15 : 3),
      .FIXED_PRI ((g == 0) ? 0 : 1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid[g]),
      .req0_data    (req0_data[g][W-1:0]),
      .req0_ready   (req0_ready[g]),
      .req1_valid   (req1_valid[g]),
      .req1_data    (req1_data[g][W-1:0]),
      .req1_ready   (req1_ready[g]),
      .done         (done[g]),
      .done_id      (done_id[g]),
      .err          (err[g]),
      .err_clr      (err_clr[g]),
      .active       (active[g]),
      .ld_write_req (ld_write_req[g]),
      .ld_address   (ld_address[g]),
      .ld_data      (ld_data[g]),
      .ld_busy      (ld_busy[g])
    );

    // Loader model: the commit write starts a busy window of busy_len cycles
    always @(posedge clk) begin
      if (!rst_n) bcnt <= 0;
      else if (ld_write_req[g] && ld_address[g] == 3'd4 && model_en[g]) bcnt <= busy_len[g];
      else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign ld_busy[g] = (bcnt != 0) || busy_force[g];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int d, input logic id, input string tag);
    int n = 0;
    while (done[d] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 64'(done[d]), 64'd1);
    chk({tag, "_id"}, 64'(done_id[d]), 64'(id));
  endtask

  initial begin
    int n;
    logic exp;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req0_valid[d] = 1'b0; req1_valid[d] = 1'b0;
      req0_data[d]  = '0;   req1_data[d]  = '0;
      err_clr[d]    = 1'b0; busy_force[d] = 1'b0;
      model_en[d]   = 1'b1; busy_len[d]   = 16;
    end
    tick(); tick();
    chk("rst_active", 64'(active[0]), 64'd0);
    chk("rst_done",   64'(done[0]), 64'd0);
    chk("rst_err",    64'(err[0]), 64'd0);
    chk("rst_wr",     64'(ld_write_req[0]), 64'd0);
    chk("rst_data",   64'(ld_data[0]), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request, 16-cycle busy
    req0_valid[0] = 1'b1;
    req0_data[0]  = 64'h0000_00AB_DEAD_BEEF;
    #1;
    chk("t1_ready0", 64'(req0_ready[0]), 64'd1);
    chk("t1_ready1", 64'(req1_ready[0]), 64'd0);
    chk("t1_idle",   64'(active[0]), 64'd0);
    tick();
    req0_valid[0] = 1'b0;
    chk("t1_lo_wr",   64'(ld_write_req[0]), 64'd1);
    chk("t1_lo_addr", 64'(ld_address[0]), 64'd0);
    chk("t1_lo_data", 64'(ld_data[0]), 64'hDEAD_BEEF);
    chk("t1_lo_act",  64'(active[0]), 64'd1);
    tick();
    chk("t1_hi_wr",   64'(ld_write_req[0]), 64'd1);
    chk("t1_hi_addr", 64'(ld_address[0]), 64'd4);
    chk("t1_hi_data", 64'(ld_data[0]), 64'h0000_00AB);
    tick();
    chk("t1_wb_wr",   64'(ld_write_req[0]), 64'd0);
    chk("t1_wb_data", 64'(ld_data[0]), 64'd0);
    chk("t1_busy",    64'(ld_busy[0]), 64'd1);
    n = 0;
    while (ld_busy[0] && n < 40) begin
      tick();
      n++;
    end
    chk("t1_busy_len", 64'(n), 64'd16);
    chk("t1_fall_done", 64'(done[0]), 64'd0);
    chk("t1_fall_act",  64'(active[0]), 64'd1);
    tick();
    chk("t1_done",    64'(done[0]), 64'd1);
    chk("t1_done_id", 64'(done_id[0]), 64'd0);
    chk("t1_end_act", 64'(active[0]), 64'd0);
    tick();
    chk("t1_done_pulse", 64'(done[0]), 64'd0);

    // Reset during WAIT_DONE
    req0_valid[0] = 1'b1;
    #1;
    chk("t5_ready0", 64'(req0_ready[0]), 64'd1);
    tick();
    req0_valid[0] = 1'b0;
    tick(); tick(); tick();
    chk("t5_active", 64'(active[0]), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("t5_done",   64'(done[0]), 64'd0);
    chk("t5_wr",     64'(ld_write_req[0]), 64'd0);
    chk("t5_err",    64'(err[0]), 64'd0);
    chk("t5_active_rst", 64'(active[0]), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("t5_no_done", 64'(done[0]), 64'd0);
    chk("t5_no_wr",   64'(ld_write_req[0]), 64'd0);

    // Round-robin contention; first grant proves the pointer was reset to favour req0
    busy_len[0]   = 2;
    req0_valid[0] = 1'b1; req0_data[0] = 64'h1111_1111_A0A0_A0A0;
    req1_valid[0] = 1'b1; req1_data[0] = 64'h2222_2222_B1B1_B1B1;
    for (int k = 0; k < 4; k++) begin
      exp = 1'(k % 2);
      #1;
      chk("t2_ready0", 64'(req0_ready[0]), 64'(!exp));
      chk("t2_ready1", 64'(req1_ready[0]), 64'(exp));
      tick();
      chk("t2_lo_data", 64'(ld_data[0]), exp ? 64'hB1B1_B1B1 : 64'hA0A0_A0A0);
      wait_done(0, exp, "t2");
    end
    req0_valid[0] = 1'b0; req1_valid[0] = 1'b0;
    tick();

    // Fixed priority: req1 starved while req0 is valid
    busy_len[1]   = 2;
    req0_valid[1] = 1'b1; req0_data[1] = 64'h0000_0101_0202_0303;
    req1_valid[1] = 1'b1; req1_data[1] = 64'h0000_0404_0505_0606;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fp_ready0", 64'(req0_ready[1]), 64'd1);
      chk("fp_ready1", 64'(req1_ready[1]), 64'd0);
      tick();
      wait_done(1, 1'b0, "fp");
    end
    req0_valid[1] = 1'b0;
    #1;
    chk("fp_req1_ready", 64'(req1_ready[1]), 64'd1);
    tick();
    req1_valid[1] = 1'b0;
    wait_done(1, 1'b1, "fp_r1");

    // Loader never goes busy
    model_en[0]   = 1'b0;
    req0_valid[0] = 1'b1;
    #1;
    chk("t3_ready0", 64'(req0_ready[0]), 64'd1);
    tick();
    req0_valid[0] = 1'b0;
    repeat (16) tick();
    chk("t3_err_pre", 64'(err[0]), 64'd0);
    chk("t3_act_pre", 64'(active[0]), 64'd1);
    tick();
    chk("t3_err",    64'(err[0]), 64'd1);
    chk("t3_active", 64'(active[0]), 64'd0);
    chk("t3_done",   64'(done[0]), 64'd0);
    model_en[0]   = 1'b1;
    req1_valid[0] = 1'b1;
    #1;
    chk("t3_next_ready", 64'(req1_ready[0]), 64'd1);
    tick();
    req1_valid[0] = 1'b0;
    wait_done(0, 1'b1, "t3_next");
    chk("t3_err_sticky", 64'(err[0]), 64'd1);
    err_clr[0] = 1'b1;
    tick();
    err_clr[0] = 1'b0;
    chk("t3_err_clr", 64'(err[0]), 64'd0);

    // Loader busy while idle blocks the grant
    busy_force[0] = 1'b1;
    req1_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_blocked", 64'(req1_ready[0]), 64'd0);
      tick();
    end
    busy_force[0] = 1'b0;
    #1;
    chk("t4_ready1", 64'(req1_ready[0]), 64'd1);
    tick();
    req1_valid[0] = 1'b0;
    wait_done(0, 1'b1, "t4");

    // WIDTH=48 split and timeout/clear collision
    model_en[1]   = 1'b0;
    req0_valid[1] = 1'b1;
    req0_data[1]  = 64'h0000_ABCD_1234_5678;
    #1;
    chk("t6_ready0", 64'(req0_ready[1]), 64'd1);
    tick();
    req0_valid[1] = 1'b0;
    chk("t6_lo_addr", 64'(ld_address[1]), 64'd0);
    chk("t6_lo_data", 64'(ld_data[1]), 64'h1234_5678);
    tick();
    chk("t6_hi_wr",   64'(ld_write_req[1]), 64'd1);
    chk("t6_hi_addr", 64'(ld_address[1]), 64'd4);
    chk("t6_hi_data", 64'(ld_data[1]), 64'h0000_ABCD);
    tick(); tick(); tick();
    chk("t6_err_pre", 64'(err[1]), 64'd0);
    chk("t6_act_pre", 64'(active[1]), 64'd1);
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    chk("t6_err_set_wins", 64'(err[1]), 64'd1);
    chk("t6_active", 64'(active[1]), 64'd0);
    chk("t6_done",   64'(done[1]), 64'd0);
    err_clr[1] = 1'b1;
    tick();
    err_clr[1] = 1'b0;
    chk("t6_err_clr", 64'(err[1]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
